// File: rtl/linear_inflight_tracker.sv
// linear_inflight_tracker: queues Allocator slot IDs, dispatches them, tracks in-flight slots and returns completions in order; optional stall counter under LINEAR_TRACKER_STALL_CNT_EN
module linear_inflight_tracker #(
  parameter int IDW   = 4,
  parameter int DEPTH = 8,
  parameter int CW    = 16
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           linear_rdy,
  output logic           linear_ack,
  input  logic [IDW-1:0] i_linear_id,
  output logic           dispatch_rdy,
  input  logic           dispatch_ack,
  output logic [IDW-1:0] o_dispatch_id,
  input  logic           done_rdy,
  output logic           done_ack,
  output logic           free_rdy,
  input  logic           free_ack,
  output logic [IDW-1:0] o_free_id,
  output logic [CW-1:0]  o_stall_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  logic [IDW-1:0] mem_q [DEPTH];
  logic [PW-1:0]  wp_q, wp_d, dp_q, dp_d, rp_q, rp_d;
  logic [PW-1:0]  occ, pend, infl;
  logic           free_rdy_q, free_rdy_d;
  logic [IDW-1:0] free_id_q, free_id_d;
  logic           push, disp, done;
  // handshakes and next-state; acks are held low during reset so nothing appears to transfer
  always_comb begin
    occ           = wp_q - rp_q;
    pend          = wp_q - dp_q;
    infl          = dp_q - rp_q;
    linear_ack    = linear_rdy && !i_rst && (occ != PW'(DEPTH));
    dispatch_rdy  = pend != '0;
    o_dispatch_id = mem_q[dp_q[AW-1:0]];
    done_ack      = done_rdy && !i_rst && (infl != '0) && (!free_rdy_q || free_ack);
    push          = linear_ack;
    disp          = dispatch_rdy && dispatch_ack;
    done          = done_ack;
    wp_d          = wp_q + PW'(push);
    dp_d          = dp_q + PW'(disp);
    rp_d          = rp_q + PW'(done);
    free_rdy_d    = done ? 1'b1 : (free_ack ? 1'b0 : free_rdy_q);
    free_id_d     = done ? mem_q[rp_q[AW-1:0]] : free_id_q;
  end
  // pointers and the registered free output
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wp_q       <= '0;
      dp_q       <= '0;
      rp_q       <= '0;
      free_rdy_q <= 1'b0;
      free_id_q  <= '0;
    end else begin
      wp_q       <= wp_d;
      dp_q       <= dp_d;
      rp_q       <= rp_d;
      free_rdy_q <= free_rdy_d;
      free_id_q  <= free_id_d;
    end
  end
  // slot ID storage; contents are don't-care after reset
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wp_q[AW-1:0]] <= i_linear_id;
  end
  assign free_rdy  = free_rdy_q;
  assign o_free_id = free_id_q;
`ifdef LINEAR_TRACKER_STALL_CNT_EN
  logic [CW-1:0] stall_q, stall_d;
  // saturating count of cycles the Allocator was back-pressured
  always_comb begin
    stall_d = (linear_rdy && !linear_ack && stall_q != '1) ? stall_q + 1'b1 : stall_q;
  end
  // stall counter register
  always_ff @(posedge i_clk) begin
    if (i_rst) stall_q <= '0;
    else stall_q <= stall_d;
  end
  assign o_stall_cnt = stall_q;
`else
  assign o_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_linear_inflight_tracker.sv
// tb_linear_inflight_tracker: directed vector table, corner sequences and a random scoreboard run
module tb_linear_inflight_tracker;
  logic i_clk = 0, i_rst = 1;
  logic linear_rdy = 0, linear_ack, dispatch_rdy, dispatch_ack = 0;
  logic done_rdy = 0, done_ack, free_rdy, free_ack = 0;
  logic [3:0] i_linear_id = 0, o_dispatch_id, o_free_id;
  logic [15:0] o_stall_cnt;
  int checks = 0, errors = 0;

  linear_inflight_tracker #(.IDW(4), .DEPTH(8), .CW(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .linear_rdy(linear_rdy), .linear_ack(linear_ack), .i_linear_id(i_linear_id),
    .dispatch_rdy(dispatch_rdy), .dispatch_ack(dispatch_ack), .o_dispatch_id(o_dispatch_id),
    .done_rdy(done_rdy), .done_ack(done_ack),
    .free_rdy(free_rdy), .free_ack(free_ack), .o_free_id(o_free_id),
    .o_stall_cnt(o_stall_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic rst, lr; logic [3:0] lid; logic da, dr, fa;
    logic lack, drdy; logic [3:0] did; logic dack, frdy; logic [3:0] fid;
  } vec_t;
  vec_t v[$];

  function automatic void add(logic rst, logic lr, logic [3:0] lid, logic da, logic dr, logic fa,
                              logic lack, logic drdy, logic [3:0] did, logic dack, logic frdy, logic [3:0] fid);
    vec_t e;
    e.rst = rst; e.lr = lr; e.lid = lid; e.da = da; e.dr = dr; e.fa = fa;
    e.lack = lack; e.drdy = drdy; e.did = did; e.dack = dack; e.frdy = frdy; e.fid = fid;
    v.push_back(e);
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int pq[$], iq[$];
    logic frdy_m, lr_hold, dr_hold, e_lack, e_drdy, e_dack;
    logic [3:0] fid_m;
    int pushes, frees;
    logic [3:0] exp_ids [5];
    // reset, single push, single dispatch/done/free
    add(1,1,3,0,0,0, 0,0,0,0,0,0);
    add(0,1,3,0,0,0, 1,0,0,0,0,0);
    add(0,0,0,1,0,0, 0,1,3,0,0,0);
    add(0,0,0,0,1,0, 0,0,0,1,0,0);
    add(0,0,0,0,0,1, 0,0,0,0,1,3);
    add(0,0,0,0,0,0, 0,0,0,0,0,3);
    add(1,0,0,0,0,0, 0,0,0,0,0,3);
    // fill to DEPTH, 9th push refused
    for (int k = 0; k < 8; k++) add(0,1,4'(k),0,0,0, 1,k > 0,0,0,0,0);
    add(0,1,9,0,0,0, 0,1,0,0,0,0);
    add(0,1,9,1,0,0, 0,1,0,0,0,0);
    add(0,1,9,1,0,0, 0,1,1,0,0,0);
    add(0,1,9,0,1,0, 0,1,2,1,0,0);
    add(0,1,9,0,0,0, 1,1,2,0,1,0);
    add(0,0,0,0,0,1, 0,1,2,0,1,0);
    // in-flight 1,2,3; done held off by free backpressure, then back-to-back
    add(0,0,0,1,0,0, 0,1,2,0,0,0);
    add(0,0,0,1,0,0, 0,1,3,0,0,0);
    add(0,0,0,0,1,0, 0,1,4,1,0,0);
    add(0,0,0,0,1,0, 0,1,4,0,1,1);
    add(0,0,0,0,1,0, 0,1,4,0,1,1);
    add(0,0,0,0,1,1, 0,1,4,1,1,1);
    add(0,0,0,0,1,1, 0,1,4,1,1,2);
    add(0,0,0,0,1,1, 0,1,4,0,1,3);
    add(0,0,0,0,1,0, 0,1,4,0,0,3);

    repeat (2) @(posedge i_clk);
    foreach (v[i]) begin
      @(negedge i_clk);
      i_rst = v[i].rst; linear_rdy = v[i].lr; i_linear_id = v[i].lid;
      dispatch_ack = v[i].da; done_rdy = v[i].dr; free_ack = v[i].fa;
      #1;
      chk($sformatf("v%0d linear_ack", i), linear_ack, v[i].lack);
      chk($sformatf("v%0d dispatch_rdy", i), dispatch_rdy, v[i].drdy);
      if (v[i].drdy) chk($sformatf("v%0d dispatch_id", i), o_dispatch_id, v[i].did);
      chk($sformatf("v%0d done_ack", i), done_ack, v[i].dack);
      chk($sformatf("v%0d free_rdy", i), free_rdy, v[i].frdy);
      chk($sformatf("v%0d free_id", i), o_free_id, v[i].fid);
    end

    // done with nothing in flight is never acked
    for (int i = 0; i < 20; i++) begin
      @(negedge i_clk);
      done_rdy = 1; free_ack = 0; dispatch_ack = 0; linear_rdy = 0;
      #1;
      chk("orphan done_ack", done_ack, 0);
      chk("orphan free_rdy", free_rdy, 0);
    end
    // pointers undisturbed: remaining queue dispatches 4,5,6,7 then wrapped 9
    exp_ids = '{4'd4, 4'd5, 4'd6, 4'd7, 4'd9};
    for (int i = 0; i < 6; i++) begin
      @(negedge i_clk);
      done_rdy = 0; dispatch_ack = (i < 5);
      #1;
      chk("drain dispatch_rdy", dispatch_rdy, i < 5);
      if (i < 5) chk("drain dispatch_id", o_dispatch_id, exp_ids[i]);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge i_clk);
      dispatch_ack = 0; done_rdy = (i < 5); free_ack = 1;
      #1;
      if (i < 5) chk("drain done_ack", done_ack, 1);
      if (i > 0) begin
        chk("drain free_rdy", free_rdy, 1);
        chk("drain free_id", o_free_id, exp_ids[i-1]);
      end
    end
    @(negedge i_clk);
    done_rdy = 0; free_ack = 0;
    #1;
    chk("drained free_rdy", free_rdy, 0);
    chk("drained dispatch_rdy", dispatch_rdy, 0);

    // random traffic against a queue model
    @(negedge i_clk);
    i_rst = 1; linear_rdy = 0; dispatch_ack = 0; done_rdy = 0; free_ack = 0;
    @(posedge i_clk);
    frdy_m = 0; fid_m = 0; lr_hold = 0; dr_hold = 0; pushes = 0; frees = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge i_clk);
      i_rst = 0;
      if (!lr_hold) begin
        linear_rdy = ($urandom % 4) != 0;
        i_linear_id = 4'(pushes);
      end
      dispatch_ack = $urandom % 2;
      if (!dr_hold) done_rdy = (iq.size() != 0) && ($urandom % 2 == 1);
      free_ack = $urandom % 2;
      #1;
      e_lack = linear_rdy && (pq.size() + iq.size() != 8);
      e_drdy = pq.size() != 0;
      e_dack = done_rdy && (iq.size() != 0) && (!frdy_m || free_ack);
      chk("rnd linear_ack", linear_ack, e_lack);
      chk("rnd dispatch_rdy", dispatch_rdy, e_drdy);
      if (e_drdy) chk("rnd dispatch_id", o_dispatch_id, pq[0]);
      chk("rnd done_ack", done_ack, e_dack);
      chk("rnd free_rdy", free_rdy, frdy_m);
      if (frdy_m) chk("rnd free_id", o_free_id, fid_m);
      if (frdy_m && free_ack) frees++;
      if (e_dack) begin
        fid_m = 4'(iq.pop_front());
        frdy_m = 1;
      end else if (frdy_m && free_ack) frdy_m = 0;
      if (e_drdy && dispatch_ack) iq.push_back(pq.pop_front());
      if (e_lack) begin
        pq.push_back(int'(i_linear_id));
        pushes++;
      end
      lr_hold = linear_rdy && !e_lack;
      dr_hold = done_rdy && !e_dack;
    end
    chk("rnd wrap coverage", frees >= 32, 1);

`ifdef LINEAR_TRACKER_STALL_CNT_EN
    @(negedge i_clk);
    i_rst = 1; linear_rdy = 0; dispatch_ack = 0; done_rdy = 0; free_ack = 0;
    @(negedge i_clk);
    i_rst = 0;
    #1;
    chk("stall after reset", o_stall_cnt, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge i_clk);
      linear_rdy = 1; i_linear_id = 4'(i);
    end
    repeat (11) @(negedge i_clk);
    #1;
    chk("stall count 10", o_stall_cnt, 10);
    @(negedge i_clk);
    i_rst = 1;
    @(negedge i_clk);
    i_rst = 0; linear_rdy = 0;
    #1;
    chk("stall cleared", o_stall_cnt, 0);
`else
    #1;
    chk("stall tied 0", o_stall_cnt, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/linear_inflight_tracker.md
Name: linear_inflight_tracker

Overview:
Sits directly downstream of the Allocator and consumes its linear output: every granted slot ID is queued, then dispatched to the compute stage. Dispatched slots are tracked as in-flight until a completion handshake arrives. Completed slots are returned in order on a free handshake, which the top level routes back to the Allocator's release path.

Parameters:
IDW, 4, width of slot ID carried on linear/dispatch/free
DEPTH, 8, queue capacity in slots; power of two, >= 2
CW, 16, stall counter width (used only with the optional feature)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset; synchronous, active-high
linear_rdy  in  1  Allocator presents slot ID
linear_ack  out  1  tracker accepts slot ID
i_linear_id  in  IDW  slot ID from Allocator
dispatch_rdy  out  1  queued slot ready for compute
dispatch_ack  in  1  compute accepts slot
o_dispatch_id  out  IDW  slot ID being dispatched
done_rdy  in  1  compute reports completion of oldest in-flight slot
done_ack  out  1  completion accepted
free_rdy  out  1  completed slot available for release
free_ack  in  1  release path accepts slot
o_free_id  out  IDW  slot ID being released
o_stall_cnt  out  CW  linear stall cycles (optional feature; tied 0 otherwise)

Behaviour:
- Handshake: a transfer occurs on a rising clock edge where rdy && ack. Producers hold rdy and data stable until ack. An ack may depend combinationally on its rdy; an ack never causes a rdy change in the same cycle.
- Storage: circular buffer of DEPTH x IDW. Three pointers, each log2(DEPTH)+1 bits with wrap bit: wp (push), dp (dispatch), rp (retire). Invariant: rp <= dp <= wp modulo wrap. occ = wp-rp; pend = wp-dp; infl = dp-rp.
- linear_ack = linear_rdy && (occ != DEPTH). On transfer: buf[wp] <= i_linear_id; wp++.
- dispatch_rdy = (pend != 0). o_dispatch_id = buf[dp]. On transfer: dp++.
- Latency: an ID accepted at edge N drives dispatch_rdy from cycle N+1. There is no bypass.
- done_ack = done_rdy && (infl != 0) && (!free_rdy || free_ack). On transfer: free_rdy <= 1; o_free_id <= buf[rp]; rp++.
- Registered free output: on free transfer without a simultaneous done, free_rdy <= 0. With a simultaneous done, free_rdy stays 1 and o_free_id loads the new ID.
- done_rdy while infl == 0: done_ack stays 0 and no state changes. This case is a protocol error; the tracker never acks it.
- The slot is freed from the queue (rp++) at done time, not at free time. linear_ack can therefore rise in the cycle after a done transfer on a full queue.
- Simultaneous events: push, dispatch and done in the same cycle are all legal and update independent pointers. Full with a simultaneous done: no push that cycle, because linear_ack uses the registered occ.
- Reset (i_rst=1 at an edge): wp=dp=rp=0, free_rdy=0, o_free_id=0, o_stall_cnt=0. Buffer contents are not reset. Consequences: dispatch_rdy=0 and linear_ack=0. Reset mid-operation discards all queued and in-flight IDs.

Optional Feature:
LINEAR_TRACKER_STALL_CNT_EN
- Defined: o_stall_cnt increments on every cycle where linear_rdy && !linear_ack. It saturates at 2^CW-1 and clears on reset. This is a backpressure monitor for the Allocator.
- Undefined: no counter logic is built and o_stall_cnt is driven constant 0.

Test Plan:
- Reset, then push ID 3 -> dispatch_rdy=1 exactly one cycle later with o_dispatch_id=3; linear_ack=0 throughout reset.
- Push IDs 0..7 (DEPTH=8) with dispatch_ack=0 -> linear_ack=0 on 9th attempt. Dispatch 2, then done once -> linear_ack returns the next cycle; free emits ID 0.
- Dispatch 0,1,2; done x3 with free_ack=0 -> only the first done acked, o_free_id=0 held. Then free_ack=1 continuously -> frees emitted in order 1, then 2, with done and free overlapping back-to-back.
- done_rdy=1 with nothing dispatched -> done_ack=0 for 20 cycles; pointers unchanged; free_rdy=0.
- Randomized linear_rdy/dispatch_ack/done_rdy/free_ack for 2000 cycles with a scoreboard -> free order equals linear order; no ID lost or duplicated; pointer wrap covered at least 4 times.
- With LINEAR_TRACKER_STALL_CNT_EN defined: hold full for 10 cycles with linear_rdy=1 -> o_stall_cnt=10. Assert i_rst -> count 0 next cycle.
